// File: rtl/platform_scheduler.sv
// Per-frame platform scheduler: scrolls every slot, then respawns slots that fell off screen.
// Optional horizontal motion of odd slots is enabled with `define PLATFORM_MOVE_EN.
module platform_scheduler #(
  parameter int          N_PLAT    = 8,
  parameter int          H         = 240,
  parameter int          X_MIN     = 80,
  parameter int          X_MAX     = 240,
  parameter int          PLAT_W    = 20,
  parameter int          GAP       = 30,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  frame_clk,
  input  logic [4:0]            scroll_amt,
  output logic [10*N_PLAT-1:0]  Platform_X_flat,
  output logic [10*N_PLAT-1:0]  Platform_Y_flat,
  output logic                  busy,
  output logic                  frame_done,
  output logic [3:0]            respawn_cnt,
  output logic                  overrun,
  output logic [1:0]            dbg_state
);

  localparam int IDX_W = (N_PLAT > 1) ? $clog2(N_PLAT) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_PLAT - 1);
  localparam logic [9:0] H_M1    = 10'(H - 1);
  localparam logic [9:0] GAP_L   = 10'(GAP);
  localparam logic [9:0] X_MIN_L = 10'(X_MIN);
  localparam logic [9:0] SPAN_L  = 10'(X_MAX - X_MIN - PLAT_W);
  localparam logic [9:0] MINY_NONE = 10'h3FF;
`ifdef PLATFORM_MOVE_EN
  localparam logic [9:0] X_MAX_L = 10'(X_MAX);
  localparam logic [9:0] PW_L    = 10'(PLAT_W);
`endif

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SCROLL  = 2'd1,
    S_RESPAWN = 2'd2,
    S_DONE    = 2'd3
  } state_e;

  state_e state_q, state_d;

  logic sync1_q, sync2_q, sync3_q, start_q;
  logic [15:0] lfsr_q;

  logic [IDX_W-1:0] idx_q, idx_d;
  logic [9:0]       miny_q, miny_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [4:0]       scroll_q, scroll_d;
  logic [3:0]       rcnt_q, rcnt_d;
  logic [9:0]       px_q [N_PLAT];
  logic [9:0]       px_d [N_PLAT];
  logic [9:0]       py_q [N_PLAT];
  logic [9:0]       py_d [N_PLAT];
`ifdef PLATFORM_MOVE_EN
  logic [N_PLAT-1:0] dir_q, dir_d;
  logic [9:0]        cur_x;
`endif

  logic [9:0] cur_y, scrolled_y, respawn_y, r10, off, respawn_x;

  // frame_clk is asynchronous: two flops for metastability, a third for edge detection.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
      start_q <= 1'b0;
      lfsr_q  <= LFSR_SEED;
    end else begin
      sync1_q <= frame_clk;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
      start_q <= sync2_q & ~sync3_q;
      lfsr_q  <= {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      idx_q    <= '0;
      miny_q   <= MINY_NONE;
      cnt_q    <= '0;
      scroll_q <= '0;
      rcnt_q   <= '0;
      for (int i = 0; i < N_PLAT; i++) begin
        px_q[i] <= 10'(X_MIN + 16 * i);
        py_q[i] <= 10'(H - 1 - GAP * i);
      end
`ifdef PLATFORM_MOVE_EN
      dir_q <= '1;
`endif
    end else begin
      idx_q    <= idx_d;
      miny_q   <= miny_d;
      cnt_q    <= cnt_d;
      scroll_q <= scroll_d;
      rcnt_q   <= rcnt_d;
      px_q     <= px_d;
      py_q     <= py_d;
`ifdef PLATFORM_MOVE_EN
      dir_q <= dir_d;
`endif
    end
  end

  // Respawn position: stack GAP above the highest visible platform, fold LFSR byte into the legal span.
  always_comb begin
    cur_y      = py_q[idx_q];
    scrolled_y = cur_y + {5'd0, scroll_q};
    if (miny_q == MINY_NONE)  respawn_y = '0;
    else if (miny_q >= GAP_L) respawn_y = miny_q - GAP_L;
    else                      respawn_y = '0;
    r10       = {2'b00, lfsr_q[7:0]};
    off       = (r10 > SPAN_L) ? (r10 - (SPAN_L + 10'd1)) : r10;
    respawn_x = X_MIN_L + off;
`ifdef PLATFORM_MOVE_EN
    cur_x = px_q[idx_q];
`endif
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    miny_d     = miny_q;
    cnt_d      = cnt_q;
    scroll_d   = scroll_q;
    rcnt_d     = rcnt_q;
    px_d       = px_q;
    py_d       = py_q;
`ifdef PLATFORM_MOVE_EN
    dir_d      = dir_q;
`endif
    busy       = (state_q != S_IDLE);
    frame_done = 1'b0;
    overrun    = start_q && (state_q != S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (start_q) begin
          scroll_d = scroll_amt;
          idx_d    = '0;
          miny_d   = MINY_NONE;
          cnt_d    = '0;
          state_d  = S_SCROLL;
        end
      end
      S_SCROLL: begin
        py_d[idx_q] = scrolled_y;
        if ((scrolled_y <= H_M1) && (scrolled_y < miny_q)) miny_d = scrolled_y;
`ifdef PLATFORM_MOVE_EN
        // The turn is taken one pixel early so the next step stays inside the playfield.
        if (idx_q[0]) begin
          if (dir_q[idx_q]) begin
            px_d[idx_q] = cur_x + 10'd1;
            if (cur_x + 10'd2 + PW_L >= X_MAX_L) dir_d[idx_q] = 1'b0;
          end else begin
            px_d[idx_q] = cur_x - 10'd1;
            if (cur_x - 10'd2 <= X_MIN_L) dir_d[idx_q] = 1'b1;
          end
        end
`endif
        if (idx_q == IDX_LAST) begin
          idx_d   = '0;
          state_d = S_RESPAWN;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_RESPAWN: begin
        if (cur_y > H_M1) begin
          py_d[idx_q] = respawn_y;
          px_d[idx_q] = respawn_x;
          miny_d      = respawn_y;
          cnt_d       = cnt_q + 4'd1;
`ifdef PLATFORM_MOVE_EN
          dir_d[idx_q] = 1'b1;
`endif
        end
        if (idx_q == IDX_LAST) state_d = S_DONE;
        else                   idx_d   = idx_q + 1'b1;
      end
      S_DONE: begin
        frame_done = 1'b1;
        rcnt_d     = cnt_q;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    for (int i = 0; i < N_PLAT; i++) begin
      Platform_X_flat[10*i +: 10] = px_q[i];
      Platform_Y_flat[10*i +: 10] = py_q[i];
    end
  end

  assign respawn_cnt = rcnt_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_platform_scheduler.sv
// Bench for platform_scheduler: frame-level reference model, per-cycle compare, directed and random frames.
// Build with +define+PLATFORM_MOVE_EN to exercise the horizontal-motion option.
module tb_platform_scheduler;

  localparam int N      = 8;
  localparam int H      = 240;
  localparam int X_MIN  = 80;
  localparam int X_MAX  = 240;
  localparam int PLAT_W = 20;
  localparam int GAP    = 30;
  localparam int SPAN   = X_MAX - X_MIN - PLAT_W;

  logic          Clk = 1'b0;
  logic          Reset;
  logic          frame_clk;
  logic [4:0]    scroll_amt;
  logic [10*N-1:0] Platform_X_flat, Platform_Y_flat;
  logic          busy, frame_done, overrun;
  logic [3:0]    respawn_cnt;
  logic [1:0]    dbg_state;

  platform_scheduler dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .scroll_amt(scroll_amt),
    .Platform_X_flat(Platform_X_flat), .Platform_Y_flat(Platform_Y_flat),
    .busy(busy), .frame_done(frame_done), .respawn_cnt(respawn_cnt),
    .overrun(overrun), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset sampling ----------------
  always #10 Clk = ~Clk;
  logic rst_at_edge = 1'b0;
  always @(posedge Clk) rst_at_edge <= Reset;

  // ---------------- reference model state ----------------
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc;
  logic [15:0] lfsr_m;
  logic [15:0] lhist [int];
  int          ex [N];
  int          ey [N];
  bit          edir [N];
  bit          fc_prev;
  int          starts [$];
  bit          active;
  int          s0;
  int          sc_lat;
  int          exp_cnt;
  int          n_done = 0;
  int          n_ovr = 0;
  int          last_done_cyc = 0;
  int          t_rise = 0;
  logic [3:0]  exp_q [$];
  bit          sb_pending;
  logic [3:0]  sb_exp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic int dut_x(input int i);
    return int'(Platform_X_flat[10*i +: 10]);
  endfunction

  function automatic int dut_y(input int i);
    return int'(Platform_Y_flat[10*i +: 10]);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      ex[i]   = X_MIN + 16 * i;
      ey[i]   = H - 1 - GAP * i;
      edir[i] = 1'b1;
    end
    cyc = 0;
    lfsr_m = 16'hACE1;
    lhist.delete();
    lhist[0] = lfsr_m;
    fc_prev = 1'b0;
    starts.delete();
    active = 1'b0;
    exp_cnt = 0;
    exp_q.delete();
    sb_pending = 1'b0;
  endtask

  // Whole-frame result: scroll everything, then respawn invisible slots in slot order.
  task automatic compute_frame();
    int ny [N];
    int miny, cnt, r, off, nv;
    miny = 1023;
    cnt = 0;
    for (int i = 0; i < N; i++) begin
      ny[i] = ey[i] + sc_lat;
`ifdef PLATFORM_MOVE_EN
      if (i % 2 == 1) begin
        if (edir[i]) begin
          ex[i] = ex[i] + 1;
          if (ex[i] + 1 + PLAT_W >= X_MAX) edir[i] = 1'b0;
        end else begin
          ex[i] = ex[i] - 1;
          if (ex[i] - 1 <= X_MIN) edir[i] = 1'b1;
        end
      end
`endif
      if (ny[i] <= H - 1 && ny[i] < miny) miny = ny[i];
    end
    for (int i = 0; i < N; i++) begin
      if (ny[i] > H - 1) begin
        if (miny == 1023)     nv = 0;
        else if (miny >= GAP) nv = miny - GAP;
        else                  nv = 0;
        ny[i] = nv;
        miny  = nv;
        // Slot i is handled 10+i edges after start, using the LFSR value held just before that edge.
        r   = int'(lhist[s0 + 9 + i] & 16'h00FF);
        off = (r > SPAN) ? r - (SPAN + 1) : r;
        ex[i]   = X_MIN + off;
        edir[i] = 1'b1;
        cnt++;
      end
    end
    for (int i = 0; i < N; i++) ey[i] = ny[i];
    exp_cnt = cnt;
    exp_q.push_back(4'(cnt));
  endtask

  // ---------------- per-cycle model step and compare ----------------
  always @(negedge Clk) begin : cmp_proc
    bit eb, ed, eo;
    eb = 1'b0; ed = 1'b0; eo = 1'b0;
    if (Reset || rst_at_edge) begin
      model_reset();
    end else begin
      cyc++;
      lfsr_m = lfsr_step(lfsr_m);
      lhist[cyc] = lfsr_m;
      if (active && cyc == s0 + 18) active = 1'b0;
      if (starts.size() > 0 && starts[0] == cyc) begin
        void'(starts.pop_front());
        if (active) eo = 1'b1;
        else begin
          active = 1'b1;
          s0     = cyc;
          sc_lat = int'(scroll_amt);
        end
      end
      if (active && cyc == s0 + 17) begin
        compute_frame();
        ed = 1'b1;
      end
      eb = active && (cyc >= s0 + 1);
      if (frame_clk && !fc_prev) starts.push_back(cyc + 3);
      fc_prev = frame_clk;
      if (sb_pending) begin
        check("sb_respawn_cnt", respawn_cnt, sb_exp);
        sb_pending = 1'b0;
      end
    end
    check("busy", busy, eb);
    check("frame_done", frame_done, ed);
    check("overrun", overrun, eo);
    if (overrun) n_ovr++;
    if (frame_done) begin
      n_done++;
      last_done_cyc = cyc;
      if (exp_q.size() == 0) check("sb_underflow", 1, 0);
      else begin
        sb_exp = exp_q.pop_front();
        sb_pending = 1'b1;
      end
    end
    if (!eb) begin
      for (int i = 0; i < N; i++) begin
        check($sformatf("x%0d", i), dut_x(i), ex[i]);
        check($sformatf("y%0d", i), dut_y(i), ey[i]);
      end
      check("respawn_cnt", respawn_cnt, exp_cnt);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic pulse_frame();
    frame_clk = 1'b1;
    @(negedge Clk);
    #1;
    t_rise = cyc;
    repeat (3) @(posedge Clk);
    #1;
    frame_clk = 1'b0;
  endtask

  task automatic wait_frame(input string name);
    int n, d0;
    n = 0;
    d0 = n_done;
    while (n_done == d0 && n < 60) begin
      @(negedge Clk);
      #1;
      n++;
    end
    check({name, "_done_seen"}, (n_done != d0), 1);
    tick(2);
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    tick(3);
    Reset = 1'b0;
    tick(2);
  endtask

  initial begin
    #4000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    int d0, o0, mode;
    Reset = 1'b0;
    frame_clk = 1'b0;
    scroll_amt = '0;
    #1 Reset = 1'b1;
    tick(3);
    Reset = 1'b0;
    @(negedge Clk);
    #1;
    check("rst_x0", dut_x(0), 80);
    check("rst_y0", dut_y(0), 239);
    check("rst_x7", dut_x(7), 192);
    check("rst_y7", dut_y(7), 29);
    check("rst_busy", busy, 0);
    check("rst_done", frame_done, 0);
    check("rst_cnt", respawn_cnt, 0);
    tick(1);

    // scroll 5: slot0 falls off and stacks above slot7
    scroll_amt = 5'd5;
    pulse_frame();
    wait_frame("f5");
    check("f5_latency", last_done_cyc - (t_rise + 3), 17);
    check("f5_y0", dut_y(0), 4);
    check("f5_y7", dut_y(7), 34);
    check("f5_x0_range", (dut_x(0) >= 80 && dut_x(0) <= 220), 1);
    check("f5_cnt", respawn_cnt, 1);

    // scroll 0: nothing moves
    d0 = n_done;
    scroll_amt = 5'd0;
    pulse_frame();
    wait_frame("f0");
    check("f0_cnt", respawn_cnt, 0);
    check("f0_y7", dut_y(7), 34);
    check("f0_done_count", n_done - d0, 1);

    // second edge five cycles after start
    d0 = n_done;
    o0 = n_ovr;
    scroll_amt = 5'd7;
    pulse_frame();
    tick(2);
    pulse_frame();
    wait_frame("ovr");
    tick(10);
    check("ovr_count", n_ovr - o0, 1);
    check("ovr_done_count", n_done - d0, 1);

    // reset while SCROLL is at slot 3
    d0 = n_done;
    scroll_amt = 5'd9;
    pulse_frame();
    tick(4);
    Reset = 1'b1;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_x0", dut_x(0), 80);
    check("mid_rst_y0", dut_y(0), 239);
    check("mid_rst_y3", dut_y(3), 149);
    tick(3);
    Reset = 1'b0;
    tick(25);
    check("mid_rst_no_done", n_done - d0, 0);

    // random frames, back-to-back edges and occasional resets
    for (int f = 0; f < 40; f++) begin
      scroll_amt = 5'($urandom_range(0, 31));
      pulse_frame();
      mode = $urandom_range(0, 9);
      if (mode == 0) begin
        tick($urandom_range(1, 14));
        Reset = 1'b1;
        tick(2);
        Reset = 1'b0;
        tick(2);
      end else if (mode <= 2) begin
        tick($urandom_range(1, 16));
      end else begin
        wait_frame("rand");
      end
    end
    tick(40);
    check("sb_drained", exp_q.size(), 0);

`ifdef PLATFORM_MOVE_EN
    do_reset();
    scroll_amt = 5'd0;
    repeat (123) begin
      pulse_frame();
      wait_frame("mv");
    end
    check("mv_x1_123", dut_x(1), 219);
    pulse_frame();
    wait_frame("mv");
    check("mv_x1_124", dut_x(1), 218);
`endif

    tick(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
